// File: rtl/tl_ram_responder.sv
// tl_ram_responder: TileLink-UL single-beat RAM manager with a 2-entry response FIFO.
// Define TL_RAM_PARITY_EN for per-byte even parity with an inject_par_err port.
module tl_ram_responder #(
    parameter int unsigned DEPTH     = 512,
    parameter logic [32:0] BASE_ADDR = 33'h080000000
) (
    input  logic        clock,
    input  logic        reset,
`ifdef TL_RAM_PARITY_EN
    input  logic        inject_par_err,
`endif
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [1:0]  auto_in_a_bits_size,
    input  logic [9:0]  auto_in_a_bits_source,
    input  logic [32:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [1:0]  auto_in_d_bits_size,
    output logic [9:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 3;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [9:0]  source;
        logic        denied;
        logic [63:0] data;
        logic        corrupt;
    } rsp_t;

    logic [63:0] mem [DEPTH];
    rsp_t        fifo_q [2];
    logic        head_q, head_d;
    logic [1:0]  count_q, count_d;
    rsp_t        rsp;
    logic        a_fire, d_fire, wr_en, in_range, par_bad;
    logic [32:0] offset;
    logic [IW-1:0] idx;
    logic [63:0] rd_word;
    logic        unused_ok;

    assign unused_ok = ^{auto_in_a_bits_param, auto_in_a_bits_corrupt};

    assign offset   = auto_in_a_bits_address - BASE_ADDR;
    assign in_range = offset < SPAN;
    assign idx      = auto_in_a_bits_address[3 +: IW];
    assign rd_word  = mem[idx];

    assign auto_in_a_ready = reset && (count_q != 2'd2);
    assign auto_in_d_valid = count_q != 2'd0;
    assign a_fire = auto_in_a_valid && auto_in_a_ready;
    assign d_fire = auto_in_d_valid && auto_in_d_ready;

`ifdef TL_RAM_PARITY_EN
    logic [7:0] par_mem [DEPTH];

    always_comb begin
        par_bad = 1'b0;
        for (int b = 0; b < 8; b++)
            par_bad = par_bad | ((^rd_word[b*8 +: 8]) != par_mem[idx][b]);
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            for (int b = 0; b < 8; b++)
                if (auto_in_a_bits_mask[b])
                    par_mem[idx][b] <= (^auto_in_a_bits_data[b*8 +: 8]) ^ inject_par_err;
    end
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        rsp        = '0;
        rsp.size   = auto_in_a_bits_size;
        rsp.source = auto_in_a_bits_source;
        wr_en      = 1'b0;
        case (auto_in_a_bits_opcode)
            3'd0, 3'd1: begin
                rsp.opcode = 3'd0;
                rsp.denied = !in_range;
                wr_en      = a_fire && in_range;
            end
            3'd4: begin
                rsp.opcode = 3'd1;
                if (in_range) begin
                    rsp.data    = rd_word;
                    rsp.corrupt = par_bad;
                end else begin
                    rsp.denied  = 1'b1;
                    rsp.corrupt = 1'b1;
                end
            end
            3'd5: rsp.opcode = 3'd2;
            default: begin
                // Atomics are refused without touching the RAM
                rsp.opcode  = 3'd1;
                rsp.denied  = 1'b1;
                rsp.corrupt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            for (int b = 0; b < 8; b++)
                if (auto_in_a_bits_mask[b])
                    mem[idx][b*8 +: 8] <= auto_in_a_bits_data[b*8 +: 8];
    end

    assign count_d = count_q + 2'(a_fire) - 2'(d_fire);
    assign head_d  = head_q ^ d_fire;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= 2'd0;
            head_q    <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (a_fire)
                fifo_q[head_q ^ count_q[0]] <= rsp;
        end
    end

    assign auto_in_d_bits_opcode  = fifo_q[head_q].opcode;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = fifo_q[head_q].size;
    assign auto_in_d_bits_source  = fifo_q[head_q].source;
    assign auto_in_d_bits_sink    = 1'b0;
    assign auto_in_d_bits_denied  = fifo_q[head_q].denied;
    assign auto_in_d_bits_data    = fifo_q[head_q].data;
    assign auto_in_d_bits_corrupt = fifo_q[head_q].corrupt;
endmodule

// File: tb/tb_tl_ram_responder.sv
// tb_tl_ram_responder: directed and random A/D traffic against a queue/array model.
// Define TL_RAM_PARITY_EN to also exercise parity injection.
module tb_tl_ram_responder;
    localparam logic [32:0] BASE = 33'h080000000;
    localparam logic [32:0] SPAN = 33'h000001000;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [9:0]  src;
        logic        denied;
        logic [63:0] data;
        logic        corrupt;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_ready, a_valid, a_corrupt, d_ready, d_valid;
    logic [2:0]  a_opcode, a_param, d_opcode;
    logic [1:0]  a_size, d_param, d_size;
    logic [9:0]  a_source, d_source;
    logic [32:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data, d_data;
    logic        d_sink, d_denied, d_corrupt;
    logic        inj = 1'b0;

    tl_ram_responder dut (
        .clock(clk), .reset(rst_n),
`ifdef TL_RAM_PARITY_EN
        .inject_par_err(inj),
`endif
        .auto_in_a_ready(a_ready), .auto_in_a_valid(a_valid),
        .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
        .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
        .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
        .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
        .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid),
        .auto_in_d_bits_opcode(d_opcode), .auto_in_d_bits_param(d_param),
        .auto_in_d_bits_size(d_size), .auto_in_d_bits_source(d_source),
        .auto_in_d_bits_sink(d_sink), .auto_in_d_bits_denied(d_denied),
        .auto_in_d_bits_data(d_data), .auto_in_d_bits_corrupt(d_corrupt)
    );

    int checks = 0, errors = 0, npop = 0;
    logic [63:0] mm [int];
    logic [7:0]  bad [int];
    rsp_t        q [$];
    rsp_t        last;
    logic [63:0] init_words [16];

    logic [2:0]  r_op;
    logic [1:0]  r_sz;
    logic [9:0]  r_src;
    logic [32:0] r_addr;
    logic [7:0]  r_mask;
    logic [63:0] r_data;
    logic        r_corr, r_inj;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // Response follows from the opcode table and range rule; the model RAM is a word map
    function automatic rsp_t model(input logic [2:0] op, input logic [1:0] sz,
                                   input logic [9:0] src, input logic [32:0] addr,
                                   input logic [7:0] mask, input logic [63:0] data,
                                   input logic pinj);
        rsp_t r;
        logic [32:0] off;
        bit inr;
        int w;
        off = addr - BASE;
        inr = off < SPAN;
        w = int'(off / 8);
        r = '0;
        r.size = sz;
        r.src = src;
        if (op == 3'd0 || op == 3'd1) begin
            r.op = 3'd0;
            r.denied = !inr;
            if (inr) begin
                if (!mm.exists(w)) mm[w] = 64'd0;
                if (!bad.exists(w)) bad[w] = 8'd0;
                for (int b = 0; b < 8; b++)
                    if (mask[b]) begin
                        mm[w][b*8 +: 8] = data[b*8 +: 8];
                        bad[w][b] = pinj;
                    end
            end
        end else if (op == 3'd4) begin
            r.op = 3'd1;
            if (inr) begin
                r.data = mm.exists(w) ? mm[w] : 64'd0;
                r.corrupt = bad.exists(w) ? (bad[w] != 8'd0) : 1'b0;
            end else begin
                r.denied = 1'b1;
                r.corrupt = 1'b1;
            end
        end else if (op == 3'd5) begin
            r.op = 3'd2;
        end else begin
            r.op = 3'd1;
            r.denied = 1'b1;
            r.corrupt = 1'b1;
        end
        return r;
    endfunction

    task automatic compare();
        chk("a_ready", a_ready, (q.size() < 2) && rst_n);
        chk("d_valid", d_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("d_opcode", d_opcode, q[0].op);
            chk("d_size", d_size, q[0].size);
            chk("d_source", d_source, q[0].src);
            chk("d_denied", d_denied, q[0].denied);
            chk("d_data", d_data, q[0].data);
            chk("d_corrupt", d_corrupt, q[0].corrupt);
            chk("d_param_sink", {d_param, d_sink}, 3'd0);
        end
    endtask

    task automatic setreq(input logic [2:0] op, input logic [9:0] src,
                          input logic [32:0] addr, input logic [7:0] mask,
                          input logic [63:0] data);
        r_op = op; r_sz = 2'd3; r_src = src; r_addr = addr;
        r_mask = mask; r_data = data; r_corr = 1'b0;
    endtask

    task automatic cyc(input bit v, input bit dr, output bit fired);
        bit fa, fd;
        @(negedge clk);
        a_valid = v; a_opcode = r_op; a_param = 3'd0; a_size = r_sz;
        a_source = r_src; a_address = r_addr; a_mask = r_mask;
        a_data = r_data; a_corrupt = r_corr; d_ready = dr; inj = r_inj;
        #2;
        compare();
        fa = a_valid && a_ready;
        fd = d_valid && d_ready;
        if (fd) begin
            last = '{d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};
            npop++;
        end
        @(posedge clk);
        if (fd) void'(q.pop_front());
        if (fa) q.push_back(model(r_op, r_sz, r_src, r_addr, r_mask, r_data, r_inj));
        fired = fa;
    endtask

    task automatic send(input bit dr);
        bit f;
        int n;
        n = 0;
        do begin
            cyc(1'b1, dr, f);
            n++;
        end while (!f && n < 20);
        if (!f) begin
            checks++; errors++;
            $display("FAIL send_timeout got no accept want accept");
        end
    endtask

    task automatic drain();
        bit f;
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            cyc(1'b0, 1'b1, f);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d want 0", q.size());
        end
    endtask

    initial begin
        bit f;
        int nf, src, p0;
        int order [$];
        logic [32:0] wa;
        a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
        a_address = 0; a_mask = 0; a_data = 0; a_corrupt = 0; d_ready = 0;
        r_inj = 1'b0;
        setreq(3'd5, 10'd0, BASE, 8'h00, 64'd0);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_d_valid", d_valid, 1'b0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_d_data", d_data, 64'd0);
        chk("rst_d_opcode", d_opcode, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, f);
        #1 chk("post_rst_a_ready", a_ready, 1'b1);

        for (int w = 0; w < 16; w++) begin
            init_words[w] = {$urandom(), $urandom()};
            setreq(3'd0, 10'(w), BASE + 33'(w * 8), 8'hFF, init_words[w]);
            send(1'b1);
        end
        drain();

        wa = 33'h080000010;
        setreq(3'd0, 10'h3A, wa, 8'hFF, 64'h1122334455667788);
        send(1'b1); drain();
        chk("put_ack_op", last.op, 3'd0);
        chk("put_ack_src", last.src, 10'h3A);
        chk("put_ack_denied", last.denied, 1'b0);
        setreq(3'd4, 10'h3B, wa, 8'h00, 64'd0);
        send(1'b1); drain();
        chk("get_op", last.op, 3'd1);
        chk("get_data", last.data, 64'h1122334455667788);
        chk("get_denied", last.denied, 1'b0);

        setreq(3'd1, 10'h3C, wa, 8'h0F, 64'hAAAAAAAABBBBBBBB);
        send(1'b1); drain();
        setreq(3'd4, 10'h3D, wa, 8'hFF, 64'd0);
        send(1'b1); drain();
        chk("partial_data", last.data, 64'h11223344BBBBBBBB);

        nf = 0; src = 1;
        for (int c = 0; c < 4; c++) begin
            setreq(3'd4, 10'(src), wa, 8'hFF, 64'd0);
            cyc(1'b1, 1'b0, f);
            if (f) begin nf++; src++; end
        end
        #1;
        chk("bp_accepts", 64'(nf), 64'd2);
        chk("bp_a_ready", a_ready, 1'b0);
        chk("bp_head_src", d_source, 10'd1);
        p0 = npop;
        for (int c = 0; c < 12 && (src <= 3 || q.size() != 0); c++) begin
            setreq(3'd4, 10'(src), wa, 8'hFF, 64'd0);
            cyc(src <= 3, 1'b1, f);
            if (f) src++;
            if (npop != p0) begin order.push_back(int'(last.src)); p0 = npop; end
        end
        chk("bp_order_len", 64'(order.size()), 64'd3);
        if (order.size() == 3) begin
            chk("bp_order0", 64'(order[0]), 64'd1);
            chk("bp_order1", 64'(order[1]), 64'd2);
            chk("bp_order2", 64'(order[2]), 64'd3);
        end

        nf = 0;
        for (int c = 0; c < 8; c++) begin
            setreq(3'd4, 10'(c), BASE + 33'(c * 8), 8'hFF, 64'd0);
            cyc(1'b1, 1'b1, f);
            if (f) nf++;
        end
        drain();
        chk("b2b_accepts", 64'(nf), 64'd8);

        setreq(3'd4, 10'h10, 33'h000000000, 8'hFF, 64'd0);
        send(1'b1); drain();
        chk("oor_get", {last.op, last.denied, last.corrupt}, {3'd1, 1'b1, 1'b1});
        chk("oor_get_data", last.data, 64'd0);
        setreq(3'd0, 10'h11, BASE + SPAN, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
        send(1'b1); drain();
        chk("oor_put", {last.op, last.denied, last.corrupt}, {3'd0, 1'b1, 1'b0});
        setreq(3'd2, 10'h12, BASE, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
        send(1'b1); drain();
        chk("arith", {last.op, last.denied, last.corrupt}, {3'd1, 1'b1, 1'b1});
        chk("arith_data", last.data, 64'd0);
        setreq(3'd4, 10'h13, BASE, 8'hFF, 64'd0);
        send(1'b1); drain();
        chk("ram_unchanged", last.data, init_words[0]);

        setreq(3'd4, 10'h14, BASE, 8'hFF, 64'd0);
        cyc(1'b1, 1'b0, f);
        cyc(1'b1, 1'b0, f);
        @(negedge clk);
        a_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_d_valid", d_valid, 1'b0);
        chk("mid_rst_a_ready", a_ready, 1'b0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        p0 = npop;
        repeat (3) cyc(1'b0, 1'b1, f);
        #1;
        chk("no_stale_pop", 64'(npop - p0), 64'd0);
        chk("mid_rst_a_ready_after", a_ready, 1'b1);

`ifdef TL_RAM_PARITY_EN
        r_inj = 1'b1;
        setreq(3'd0, 10'h20, BASE + 33'd24, 8'hFF, 64'h0123456789ABCDEF);
        send(1'b1); drain();
        r_inj = 1'b0;
        setreq(3'd4, 10'h21, BASE + 33'd24, 8'hFF, 64'd0);
        send(1'b1); drain();
        chk("par_corrupt", {last.op, last.denied, last.corrupt}, {3'd1, 1'b0, 1'b1});
        chk("par_raw_data", last.data, 64'h0123456789ABCDEF);
`endif

        begin
            bit pend;
            pend = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if (!pend && $urandom_range(0, 3) != 0) begin
                    r_op = 3'($urandom_range(0, 5));
                    r_sz = 2'($urandom_range(0, 3));
                    r_src = 10'($urandom());
                    r_mask = 8'($urandom());
                    r_data = {$urandom(), $urandom()};
                    r_corr = 1'($urandom());
                    case ($urandom_range(0, 9))
                        0: r_addr = 33'($urandom_range(0, 255));
                        1: r_addr = BASE + SPAN + 33'($urandom_range(0, 255));
                        default: r_addr = BASE + 33'($urandom_range(0, 127));
                    endcase
`ifdef TL_RAM_PARITY_EN
                    r_inj = ($urandom_range(0, 7) == 0);
`endif
                    pend = 1'b1;
                end
                cyc(pend, $urandom_range(0, 3) != 0, f);
                if (f) pend = 1'b0;
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
